// File: rtl/sr_cmd_pkg.sv
// ============================================================================
// Module   : sr_cmd_pkg
// Purpose  : Shared types and constants for the SR command conditioner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_SET  = 2'd1,
    CMD_CLR  = 2'd2
  } cmd_t;

  localparam int c_mode_clr_wins = 0;
  localparam int c_mode_set_wins = 1;
  localparam int c_mode_drop     = 2;

  // Resolves same-cycle qualified requests into at most one command.
  function automatic cmd_t arbitrate(input logic set_q, input logic clr_q, input int mode);
    cmd_t cmd;
    cmd = CMD_NONE;
    if (set_q && clr_q) begin
      if (mode == c_mode_set_wins)
        cmd = CMD_SET;
      else if (mode == c_mode_clr_wins)
        cmd = CMD_CLR;
    end else if (set_q) begin
      cmd = CMD_SET;
    end else if (clr_q) begin
      cmd = CMD_CLR;
    end
    return cmd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_debounce.sv
// ============================================================================
// Module   : sr_debounce
// Purpose  : 2-flop synchronizer, counting debouncer and rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (r_sync2 != r_level) begin
        if (r_cnt == c_cnt_last) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_rise  <= r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/sr_cmd_conditioner.sv
// ============================================================================
// Module   : sr_cmd_conditioner
// Purpose  : Turns raw set/clear requests into spaced, exclusive S/R pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_GAP         = 2,
  parameter int CONFLICT_MODE   = 0,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic set_raw,
  input  logic clr_raw,
  input  logic en,
  output logic S,
  output logic R,
  output logic conflict,
  output logic busy
);

  import sr_cmd_pkg::*;

  localparam bit               c_has_gap  = (MIN_GAP > 0);
  localparam logic [CNT_W-1:0] c_gap_last = c_has_gap ? CNT_W'(MIN_GAP - 1) : '0;

  logic             w_set_rise;
  logic             w_clr_rise;
  cmd_t             w_req;
  cmd_t             w_cmd;
  logic             w_launch;

  state_t           r_state,   w_state_nx;
  cmd_t             r_pend,    w_pend_nx;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_nx;
  logic             r_s,       w_s_nx;
  logic             r_r,       w_r_nx;
  logic             r_conflict;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_set (
    .clk   (clk),
    .reset (reset),
    .raw   (set_raw),
    .rise  (w_set_rise)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clr (
    .clk   (clk),
    .reset (reset),
    .raw   (clr_raw),
    .rise  (w_clr_rise)
  );

  assign w_req = en ? arbitrate(w_set_rise, w_clr_rise, CONFLICT_MODE) : CMD_NONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pend     <= CMD_NONE;
      r_gap_cnt  <= '0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pend     <= w_pend_nx;
      r_gap_cnt  <= w_gap_nx;
      r_s        <= w_s_nx;
      r_r        <= w_r_nx;
      r_conflict <= w_set_rise & w_clr_rise;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pend_nx  = r_pend;
    w_gap_nx   = r_gap_cnt;
    w_s_nx     = 1'b0;
    w_r_nx     = 1'b0;
    w_cmd      = CMD_NONE;
    if (en)
      w_cmd = (w_req != CMD_NONE) ? w_req : r_pend;

    // The last busy cycle can launch directly, giving MIN_GAP+1 pulse spacing.
    case (r_state)
      ST_IDLE: w_launch = 1'b1;
      ST_EMIT: w_launch = !c_has_gap;
      ST_GAP:  w_launch = (r_gap_cnt == c_gap_last);
      default: w_launch = 1'b1;
    endcase

    if (!en)
      w_pend_nx = CMD_NONE;

    if (w_launch) begin
      w_gap_nx  = '0;
      w_pend_nx = CMD_NONE;
      if (w_cmd != CMD_NONE) begin
        w_state_nx = ST_EMIT;
        w_s_nx     = (w_cmd == CMD_SET);
        w_r_nx     = (w_cmd == CMD_CLR);
      end else begin
        w_state_nx = ST_IDLE;
      end
    end else begin
      if (r_state == ST_EMIT) begin
        w_state_nx = ST_GAP;
        w_gap_nx   = '0;
      end else begin
        w_gap_nx = r_gap_cnt + 1'b1;
      end
      if (w_req != CMD_NONE)
        w_pend_nx = w_req;
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign conflict = r_conflict;
  assign busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sr_cmd_conditioner.sv
// ============================================================================
// Module   : tb_sr_cmd_conditioner
// Purpose  : Scoreboard bench: three conflict-mode instances plus a long-gap one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_cmd_conditioner;

  typedef struct {
    logic [2:0] kind;   // {conflict, R, S}
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       set_m = 1'b0, clr_m = 1'b0, en_m = 1'b1;
  logic       set_l = 1'b0, clr_l = 1'b0, en_l = 1'b1;
  logic [3:0] s_o, r_o, c_o, b_o;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  ev_t        exp_q [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_mode
    sr_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .MIN_GAP(2), .CONFLICT_MODE(g), .CNT_W(8)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .set_raw  (set_m),
      .clr_raw  (clr_m),
      .en       (en_m),
      .S        (s_o[g]),
      .R        (r_o[g]),
      .conflict (c_o[g]),
      .busy     (b_o[g])
    );
  end

  sr_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .MIN_GAP(16), .CONFLICT_MODE(0), .CNT_W(8)) u_long (
    .clk      (clk),
    .reset    (reset),
    .set_raw  (set_l),
    .clr_raw  (clr_l),
    .en       (en_l),
    .S        (s_o[3]),
    .R        (r_o[3]),
    .conflict (c_o[3]),
    .busy     (b_o[3])
  );

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic expect_ev(input int d, input logic [2:0] k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q[d].push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  // Monitor: pops the expected event whenever an instance shows any output pulse.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      logic [2:0] obs;
      ev_t        e;
      obs = {c_o[d], r_o[d], s_o[d]};
      n_checks++;
      if (s_o[d] && r_o[d]) begin
        n_fail++;
        $display("FAIL s_and_r dut%0d cyc %0d: got S=R=1 expected exclusive", d, cyc);
      end
      if (exp_q[d].size() > 0 && exp_q[d][0].cyc < cyc) begin
        e = exp_q[d].pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_pulse dut%0d: got nothing expected %b at cyc %0d", d, e.kind, e.cyc);
      end
      if (obs != 3'b000) begin
        n_checks++;
        if (exp_q[d].size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse dut%0d cyc %0d: got %b expected none", d, cyc, obs);
        end else begin
          e = exp_q[d].pop_front();
          if (e.kind != obs || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL pulse dut%0d: got %b at cyc %0d expected %b at cyc %0d",
                     d, obs, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;

    repeat (3) @(negedge clk);
    check("reset_S", {28'd0, s_o}, 32'd0);
    check("reset_R", {28'd0, r_o}, 32'd0);
    check("reset_conflict", {28'd0, c_o}, 32'd0);
    check("reset_busy", {28'd0, b_o}, 32'd0);
    reset = 1'b0;
    wait_cyc(cyc + 3);

    // 1: single set, latency D+2 and three busy cycles
    set_m = 1'b1;
    e0 = cyc + 1;
    for (int d = 0; d < 3; d++) expect_ev(d, 3'b001, e0 + 6);
    for (int k = 5; k <= 9; k++) begin
      wait_cyc(e0 + k);
      check($sformatf("busy_t1_k%0d", k), {31'd0, b_o[0]}, {31'd0, (k >= 6 && k <= 8)});
    end
    set_m = 1'b0;
    wait_cyc(cyc + 12);

    // 2: bouncing set line never qualifies
    for (int k = 0; k < 10; k++) begin
      set_m = ~set_m;
      @(negedge clk);
    end
    set_m = 1'b0;
    wait_cyc(cyc + 12);
    check("busy_t2", {28'd0, b_o}, 32'd0);

    // 3: simultaneous rise in each conflict mode
    set_m = 1'b1;
    clr_m = 1'b1;
    e0 = cyc + 1;
    expect_ev(0, 3'b110, e0 + 6);
    expect_ev(1, 3'b101, e0 + 6);
    expect_ev(2, 3'b100, e0 + 6);
    wait_cyc(e0 + 12);
    set_m = 1'b0;
    clr_m = 1'b0;
    wait_cyc(cyc + 12);

    // 4: clr qualifies during EMIT, served MIN_GAP+1 cycles later
    set_m = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    clr_m = 1'b1;
    for (int d = 0; d < 3; d++) begin
      expect_ev(d, 3'b001, e0 + 6);
      expect_ev(d, 3'b010, e0 + 9);
    end
    wait_cyc(e0 + 14);
    set_m = 1'b0;
    clr_m = 1'b0;
    wait_cyc(cyc + 12);

    // 5a: set then clr qualify during a long gap; only the later one is emitted
    set_l = 1'b1;
    e0 = cyc + 1;
    expect_ev(3, 3'b001, e0 + 6);
    expect_ev(3, 3'b010, e0 + 23);
    wait_cyc(e0 + 6);
    set_l = 1'b0;
    wait_cyc(e0 + 12);
    set_l = 1'b1;
    wait_cyc(e0 + 14);
    clr_l = 1'b1;
    wait_cyc(e0 + 22);
    check("busy_t5a_gap_end", {31'd0, b_o[3]}, 32'd1);
    wait_cyc(e0 + 42);
    set_l = 1'b0;
    clr_l = 1'b0;
    wait_cyc(cyc + 12);

    // 5b: en dropped during the gap discards the pending clear
    set_l = 1'b1;
    e0 = cyc + 1;
    expect_ev(3, 3'b001, e0 + 6);
    wait_cyc(e0 + 6);
    clr_l = 1'b1;
    wait_cyc(e0 + 14);
    en_l = 1'b0;
    @(negedge clk);
    en_l = 1'b1;
    wait_cyc(e0 + 30);
    check("busy_t5b", {31'd0, b_o[3]}, 32'd0);
    set_l = 1'b0;
    clr_l = 1'b0;
    wait_cyc(cyc + 12);

    // 6: reset in the EMIT cycle, then one fresh pulse after full debounce
    set_m = 1'b1;
    e0 = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      expect_ev(d, 3'b001, e0 + 6);
      expect_ev(d, 3'b001, e0 + 14);
    end
    wait_cyc(e0 + 6);
    reset = 1'b1;
    wait_cyc(e0 + 7);
    check("t6_S_after_reset", {29'd0, s_o[2:0]}, 32'd0);
    check("t6_busy_after_reset", {29'd0, b_o[2:0]}, 32'd0);
    reset = 1'b0;
    wait_cyc(e0 + 25);
    set_m = 1'b0;
    wait_cyc(cyc + 12);

    for (int d = 0; d < 4; d++)
      check($sformatf("queue_empty_dut%0d", d), exp_q[d].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
